// File: rtl/huffman_gen.sv
// Frame-based symbol histogram followed by an iterative Huffman code builder.
// Counts symbols 1..NSYM over one valid burst, then emits per-symbol codes and masks.
module huffman_gen #(
  parameter int NSYM = 6,
  parameter int CW   = 8,
  parameter int LW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gray_valid,
  input  logic [7:0]           gray_data,
  output logic                 busy,
  output logic                 CNT_valid,
  output logic [NSYM*CW-1:0]   CNT,
  output logic                 code_valid,
  output logic [NSYM*LW-1:0]   HC,
  output logic [NSYM*LW-1:0]   M,
  output logic                 err
);

  localparam int WW = CW + 3;
  localparam int IW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int DW = $clog2(LW + 1);
  localparam logic [IW-1:0] LAST_SLOT  = IW'(NSYM - 1);
  localparam logic [IW-1:0] LAST_ROUND = IW'(NSYM - 2);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] COUNT    = 3'd1;
  localparam logic [2:0] OUT_CNT  = 3'd2;
  localparam logic [2:0] FIND     = 3'd3;
  localparam logic [2:0] MERGE    = 3'd4;
  localparam logic [2:0] CODE     = 3'd5;
  localparam logic [2:0] OUT_CODE = 3'd6;

  logic [2:0]      state_q, state_d;
  logic [IW-1:0]   scan_q, scan_d, round_q, round_d;
  logic            have1_q, have1_d, have2_q, have2_d;
  logic [IW-1:0]   m1_q, m1_d, m2_q, m2_d;
  logic [CW-1:0]   cnt_q [NSYM];
  logic [CW-1:0]   cnt_d [NSYM];
  logic [WW-1:0]   w_q   [NSYM];
  logic [WW-1:0]   w_d   [NSYM];
  logic [NSYM-1:0] mem_q [NSYM];
  logic [NSYM-1:0] mem_d [NSYM];
  logic [NSYM-1:0] act_q, act_d, set1_q, set1_d, set2_q, set2_d;
  logic [DW-1:0]   dep_q [NSYM];
  logic [DW-1:0]   dep_d [NSYM];
  logic [LW-1:0]   hc_q  [NSYM];
  logic [LW-1:0]   hc_d  [NSYM];
  logic [LW-1:0]   mk_q  [NSYM];
  logic [LW-1:0]   mk_d  [NSYM];
  logic            err_q, err_d;
  logic [IW-1:0]   lo, hi;

  logic                cnt_vld_q, code_vld_q, err_o_q;
  logic [NSYM*CW-1:0]  cnt_o_q;
  logic [NSYM*LW-1:0]  hc_o_q, m_o_q;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Lower weight ranks lower; on equal weight the higher slot (larger smallest member) ranks lower.
  function automatic logic ranks_below(input logic [WW-1:0] wa, input logic [IW-1:0] ia,
                                       input logic [WW-1:0] wb, input logic [IW-1:0] ib);
    return (wa < wb) || ((wa == wb) && (ia > ib));
  endfunction

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    round_d = round_q;
    have1_d = have1_q;
    have2_d = have2_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    mem_d   = mem_q;
    act_d   = act_q;
    set1_d  = set1_q;
    set2_d  = set2_q;
    dep_d   = dep_q;
    hc_d    = hc_q;
    mk_d    = mk_q;
    err_d   = err_q;
    lo      = '0;
    hi      = '0;

    if (state_q == IDLE) begin
      for (int k = 0; k < NSYM; k++) begin
        cnt_d[k] = '0;
        dep_d[k] = '0;
        hc_d[k]  = '0;
        mk_d[k]  = '0;
      end
      err_d = 1'b0;
    end

    if ((state_q == IDLE || state_q == COUNT) && gray_valid) begin
      for (int k = 0; k < NSYM; k++) begin
        if (gray_data == 8'(k + 1)) begin
          if (&cnt_d[k]) err_d = 1'b1;
          cnt_d[k] = sat_inc(cnt_d[k]);
        end
      end
    end

    case (state_q)
      IDLE:    if (gray_valid) state_d = COUNT;
      COUNT:   if (!gray_valid) state_d = OUT_CNT;
      OUT_CNT: begin
        for (int k = 0; k < NSYM; k++) begin
          w_d[k]   = WW'(cnt_q[k]);
          mem_d[k] = NSYM'(1) << k;
        end
        act_d   = '1;
        scan_d  = '0;
        round_d = '0;
        have1_d = 1'b0;
        have2_d = 1'b0;
        state_d = FIND;
      end
      FIND: begin
        if (act_q[scan_q]) begin
          if (!have1_q || ranks_below(w_q[scan_q], scan_q, w_q[m1_q], m1_q)) begin
            m2_d    = m1_q;
            have2_d = have1_q;
            m1_d    = scan_q;
            have1_d = 1'b1;
          end else if (!have2_q || ranks_below(w_q[scan_q], scan_q, w_q[m2_q], m2_q)) begin
            m2_d    = scan_q;
            have2_d = 1'b1;
          end
        end
        if (scan_q == LAST_SLOT) state_d = MERGE;
        else                     scan_d  = scan_q + 1'b1;
      end
      MERGE: begin
        // The merged node lives in the lower slot, keeping slot index equal to its smallest member.
        lo         = (m1_q < m2_q) ? m1_q : m2_q;
        hi         = (m1_q < m2_q) ? m2_q : m1_q;
        set1_d     = mem_q[m1_q];
        set2_d     = mem_q[m2_q];
        w_d[lo]    = w_q[m1_q] + w_q[m2_q];
        mem_d[lo]  = mem_q[m1_q] | mem_q[m2_q];
        act_d[hi]  = 1'b0;
        state_d    = CODE;
      end
      CODE: begin
        for (int s = 0; s < NSYM; s++) begin
          if (set1_q[s] || set2_q[s]) begin
            if (dep_q[s] < DW'(LW)) begin
              mk_d[s] = mk_q[s] | (LW'(1) << dep_q[s]);
              if (set1_q[s]) hc_d[s] = hc_q[s] | (LW'(1) << dep_q[s]);
              dep_d[s] = dep_q[s] + 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        if (round_q == LAST_ROUND) begin
          state_d = OUT_CODE;
        end else begin
          round_d = round_q + 1'b1;
          scan_d  = '0;
          have1_d = 1'b0;
          have2_d = 1'b0;
          state_d = FIND;
        end
      end
      OUT_CODE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      scan_q     <= '0;
      round_q    <= '0;
      have1_q    <= 1'b0;
      have2_q    <= 1'b0;
      cnt_vld_q  <= 1'b0;
      code_vld_q <= 1'b0;
      err_o_q    <= 1'b0;
      cnt_o_q    <= '0;
      hc_o_q     <= '0;
      m_o_q      <= '0;
    end else begin
      state_q    <= state_d;
      scan_q     <= scan_d;
      round_q    <= round_d;
      have1_q    <= have1_d;
      have2_q    <= have2_d;
      cnt_vld_q  <= (state_q == COUNT) && !gray_valid;
      code_vld_q <= (state_q == CODE) && (round_q == LAST_ROUND);
      if ((state_q == COUNT) && !gray_valid) begin
        for (int k = 0; k < NSYM; k++) cnt_o_q[k*CW +: CW] <= cnt_d[k];
      end
      if ((state_q == CODE) && (round_q == LAST_ROUND)) begin
        for (int k = 0; k < NSYM; k++) begin
          hc_o_q[k*LW +: LW] <= hc_d[k];
          m_o_q[k*LW +: LW]  <= mk_d[k];
        end
        err_o_q <= err_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    m1_q   <= m1_d;
    m2_q   <= m2_d;
    cnt_q  <= cnt_d;
    w_q    <= w_d;
    mem_q  <= mem_d;
    act_q  <= act_d;
    set1_q <= set1_d;
    set2_q <= set2_d;
    dep_q  <= dep_d;
    hc_q   <= hc_d;
    mk_q   <= mk_d;
    err_q  <= err_d;
  end

  assign busy       = (state_q != IDLE);
  assign CNT_valid  = cnt_vld_q;
  assign CNT        = cnt_o_q;
  assign code_valid = code_vld_q;
  assign HC         = hc_o_q;
  assign M          = m_o_q;
  assign err        = err_o_q;

endmodule

// File: tb/tb_huffman_gen.sv
// Scoreboard bench for huffman_gen: a 6-symbol and a 2-symbol instance, each
// checked against a list-based Huffman reference model.
module tb_huffman_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gv0 = 1'b0, gv1 = 1'b0;
  logic [7:0]  gd0 = '0, gd1 = '0;
  logic        busy0, cv0, kv0, err0, busy1, cv1, kv1, err1;
  logic [47:0] cnt0, hc0, m0;
  logic [15:0] cnt1, hc1, m1;

  always #5 clk = ~clk;

  huffman_gen #(.NSYM(6), .CW(8), .LW(8)) u0 (
    .clk(clk), .reset(reset), .gray_valid(gv0), .gray_data(gd0), .busy(busy0),
    .CNT_valid(cv0), .CNT(cnt0), .code_valid(kv0), .HC(hc0), .M(m0), .err(err0));

  huffman_gen #(.NSYM(2), .CW(8), .LW(8)) u1 (
    .clk(clk), .reset(reset), .gray_valid(gv1), .gray_data(gd1), .busy(busy1),
    .CNT_valid(cv1), .CNT(cnt1), .code_valid(kv1), .HC(hc1), .M(m1), .err(err1));

  typedef struct {
    logic [63:0] cnt;
    logic [63:0] hc;
    logic [63:0] m;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0, errors = 0, cyc = 0, seen0 = 0, seen1 = 0;
  int   frame_q[$];
  bit   use_ovr = 1'b0;
  exp_t ovr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lowest(input int mm);
    for (int b = 0; b < 8; b++) if (mm[b]) return b;
    return 8;
  endfunction

  function automatic bit better(input int wi, input int mi, input int wj, input int mj);
    return (wi < wj) || (wi == wj && lowest(mi) > lowest(mj));
  endfunction

  // Reference: repeatedly take the two lowest-ranked live nodes, prefix 1/0 onto member codewords.
  function automatic exp_t model(input int nsym, input int syms[$]);
    exp_t e;
    int tc[8], w[8], mem[8], code[8], msk[8], len[8];
    bit alive[8];
    int a, b;
    e.cnt = '0; e.hc = '0; e.m = '0; e.err = 1'b0; e.cyc = 0;
    for (int k = 0; k < 8; k++) begin
      tc[k] = 0; w[k] = 0; mem[k] = 0; code[k] = 0; msk[k] = 0; len[k] = 0; alive[k] = 0;
    end
    foreach (syms[i]) if (syms[i] >= 1 && syms[i] <= nsym) tc[syms[i]-1]++;
    for (int k = 0; k < nsym; k++) begin
      w[k] = (tc[k] > 255) ? 255 : tc[k];
      if (tc[k] > 255) e.err = 1'b1;
      e.cnt[k*8 +: 8] = w[k][7:0];
      mem[k] = 1 << k;
      alive[k] = 1'b1;
    end
    for (int r = 0; r < nsym - 1; r++) begin
      a = -1; b = -1;
      for (int i = 0; i < nsym; i++)
        if (alive[i] && (a < 0 || better(w[i], mem[i], w[a], mem[a]))) a = i;
      for (int i = 0; i < nsym; i++)
        if (alive[i] && i != a && (b < 0 || better(w[i], mem[i], w[b], mem[b]))) b = i;
      for (int s = 0; s < nsym; s++) begin
        if (mem[a][s] || mem[b][s]) begin
          if (len[s] >= 8) e.err = 1'b1;
          else begin
            if (mem[a][s]) code[s] = code[s] | (1 << len[s]);
            msk[s] = msk[s] | (1 << len[s]);
            len[s]++;
          end
        end
      end
      w[a] = w[a] + w[b];
      mem[a] = mem[a] | mem[b];
      alive[b] = 1'b0;
    end
    for (int s = 0; s < nsym; s++) begin
      e.hc[s*8 +: 8] = code[s][7:0];
      e.m[s*8 +: 8]  = msk[s][7:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (cv0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL cnt0_unexpected got CNT=%h at cycle %0d, none expected", cnt0, cyc);
        end else if (cnt0 !== q0[0].cnt[47:0] || cyc != q0[0].cyc) begin
          errors++;
          $display("FAIL cnt0 got CNT=%h cyc=%0d, want CNT=%h cyc=%0d", cnt0, cyc, q0[0].cnt[47:0], q0[0].cyc);
        end
      end
      if (kv0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL code0_unexpected got HC=%h M=%h at cycle %0d", hc0, m0, cyc);
        end else begin
          exp_t e;
          e = q0.pop_front();
          if (hc0 !== e.hc[47:0] || m0 !== e.m[47:0] || err0 !== e.err || cyc != e.cyc + 41 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL code0 got HC=%h M=%h err=%b busy=%b cyc=%0d, want HC=%h M=%h err=%b busy=1 cyc=%0d",
                     hc0, m0, err0, busy0, cyc, e.hc[47:0], e.m[47:0], e.err, e.cyc + 41);
          end
        end
        seen0++;
      end
      if (cv1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL cnt1_unexpected got CNT=%h at cycle %0d", cnt1, cyc);
        end else if (cnt1 !== q1[0].cnt[15:0] || cyc != q1[0].cyc) begin
          errors++;
          $display("FAIL cnt1 got CNT=%h cyc=%0d, want CNT=%h cyc=%0d", cnt1, cyc, q1[0].cnt[15:0], q1[0].cyc);
        end
      end
      if (kv1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL code1_unexpected got HC=%h M=%h at cycle %0d", hc1, m1, cyc);
        end else begin
          exp_t e;
          e = q1.pop_front();
          if (hc1 !== e.hc[15:0] || m1 !== e.m[15:0] || err1 !== e.err || cyc != e.cyc + 5 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL code1 got HC=%h M=%h err=%b busy=%b cyc=%0d, want HC=%h M=%h err=%b busy=1 cyc=%0d",
                     hc1, m1, err1, busy1, cyc, e.hc[15:0], e.m[15:0], e.err, e.cyc + 5);
          end
        end
        seen1++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    gv0 = 1'b0; gv1 = 1'b0;
    checks++;
    if ({busy0, cv0, kv0, err0, busy1, cv1, kv1, err1} !== 8'b0 ||
        cnt0 !== '0 || hc0 !== '0 || m0 !== '0 || cnt1 !== '0 || hc1 !== '0 || m1 !== '0) begin
      errors++;
      $display("FAIL reset_state got ctl=%b CNT=%h HC=%h M=%h / CNT=%h HC=%h M=%h, want all zero",
               {busy0, cv0, kv0, err0, busy1, cv1, kv1, err1}, cnt0, hc0, m0, cnt1, hc1, m1);
    end
  endtask

  // mode 0: normal frame; 1: reset in the middle of the samples; 2: reset during FIND.
  task automatic run_frame(input int inst, input int mode);
    exp_t e;
    int   n, target, t;
    e = use_ovr ? ovr : model(inst == 0 ? 6 : 2, frame_q);
    @(posedge clk); #1;
    e.cyc = cyc + frame_q.size() + 1;
    if (mode != 1) begin
      if (inst == 0) q0.push_back(e); else q1.push_back(e);
    end
    target = (inst == 0 ? seen0 : seen1) + 1;
    n = (mode == 1) ? frame_q.size() / 2 : frame_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (inst == 0) begin gv0 = 1'b1; gd0 = 8'(frame_q[i]); end
      else           begin gv1 = 1'b1; gd1 = 8'(frame_q[i]); end
    end
    if (mode == 1) begin
      do_reset();
      repeat (60) @(posedge clk);
      return;
    end
    @(posedge clk); #1;
    gv0 = 1'b0; gv1 = 1'b0;
    if (mode == 2) begin
      repeat (5) @(posedge clk);
      do_reset();
      if (q0.size() > 0) void'(q0.pop_front());
      repeat (60) @(posedge clk);
      return;
    end
    t = 0;
    while ((inst == 0 ? seen0 : seen1) < target && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (t >= 400) begin
      errors++; $display("FAIL frame_timeout inst=%0d got no code_valid within 400 cycles, want one", inst);
    end
    checks++;
    if ((inst == 0 ? busy0 : busy1) !== 1'b0) begin
      errors++; $display("FAIL busy_idle inst=%0d got busy=1 after code_valid, want 0", inst);
    end
  endtask

  task automatic gen_frame(input int len, input int maxsym);
    frame_q.delete();
    for (int i = 0; i < len; i++) frame_q.push_back(int'($urandom_range(0, maxsym)));
  endtask

  initial begin
    do_reset();

    // Reference frame with known codes.
    frame_q.delete();
    for (int s = 1; s <= 6; s++) begin
      int c;
      c = (s == 1) ? 40 : (s == 2) ? 30 : (s == 3) ? 16 : (s == 4) ? 8 : (s == 5) ? 4 : 3;
      for (int i = 0; i < c; i++) frame_q.push_back(s);
    end
    ovr.cnt = 64'h0000_0304_0810_1E28;
    ovr.hc  = 64'h0000_0706_0200_0101;
    ovr.m   = 64'h0000_1F1F_0F07_0301;
    ovr.err = 1'b0;
    use_ovr = 1'b1;
    run_frame(0, 0);
    use_ovr = 1'b0;

    // Saturation of a single symbol.
    frame_q.delete();
    for (int i = 0; i < 300; i++) frame_q.push_back(2);
    ovr = model(6, frame_q);
    ovr.cnt = 64'h0000_0000_0000_FF00;
    ovr.err = 1'b1;
    use_ovr = 1'b1;
    run_frame(0, 0);
    use_ovr = 1'b0;

    // Illegal values 0, 7, 200 interleaved.
    frame_q.delete();
    for (int i = 0; i < 45; i++) begin
      case (i % 4)
        0: frame_q.push_back(0);
        1: frame_q.push_back(7);
        2: frame_q.push_back(200);
        default: frame_q.push_back(int'($urandom_range(1, 6)));
      endcase
    end
    run_frame(0, 0);

    // Resets mid-frame and mid-FIND, then a clean frame.
    gen_frame(20, 6);
    run_frame(0, 1);
    gen_frame(25, 6);
    run_frame(0, 2);
    gen_frame(30, 6);
    run_frame(0, 0);

    // Two-symbol instance, single sample of symbol 1.
    frame_q.delete();
    frame_q.push_back(1);
    ovr.cnt = 64'h0001;
    ovr.hc  = 64'h0100;
    ovr.m   = 64'h0101;
    ovr.err = 1'b0;
    use_ovr = 1'b1;
    run_frame(1, 0);
    use_ovr = 1'b0;

    // All-illegal frame: every count zero, so ranking is decided purely by tie-break.
    frame_q.delete();
    for (int i = 0; i < 5; i++) frame_q.push_back(7);
    run_frame(0, 0);

    // Back-to-back randomized frames.
    for (int f = 0; f < 8; f++) begin
      gen_frame(int'($urandom_range(1, 70)), (f % 2 == 0) ? 6 : 3);
      run_frame(0, 0);
    end
    for (int f = 0; f < 4; f++) begin
      gen_frame(int'($urandom_range(1, 20)), 3);
      run_frame(1, 0);
    end

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
